// File: rtl/gtx_tx_arb.sv
// ---------------------------------------------------------------------------
// gtx_tx_arb
// Two-requester LocalLink frame arbiter in front of an Aurora TX port.
// A requester asks for the link by showing a SOF word. The granted requester
// is muxed straight through, with no added latency, until its EOF. Frames
// longer than MAX_WORDS are cut short: EOF is forced onto the last word that
// fits, and the rest of the frame is drained. If the channel goes down
// mid-frame, the output stops at once and the rest of the frame is drained.
//
// Ports
//   clk_gtp                 LocalLink user clock; the block's only clock.
//   rst_gtp_n               Active-low reset. Asserts asynchronously and
//                           releases synchronously to clk_gtp.
//   channel_up              Aurora channel status (1 = link usable).
//   sN_tx_*                 Requester LocalLink inputs. dst_rdy_n is an output.
//   gtx_tx_*                LocalLink toward Aurora TX. dst_rdy_n is an input.
//   trunc_err               1-cycle pulse: frame cut at MAX_WORDS.
//   abort_err               1-cycle pulse: channel dropped mid-frame.
//   sof_err                 1-cycle pulse: non-SOF word discarded in IDLE.
//   frm_cnt0/1              Frames completed per requester (wrapping).
// ---------------------------------------------------------------------------
module gtx_tx_arb #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk_gtp,
    input  logic        rst_gtp_n,
    input  logic        channel_up,
    input  logic [15:0] s0_tx_data,
    input  logic        s0_tx_sof_n,
    input  logic        s0_tx_eof_n,
    input  logic        s0_tx_src_rdy_n,
    output logic        s0_tx_dst_rdy_n,
    input  logic [15:0] s1_tx_data,
    input  logic        s1_tx_sof_n,
    input  logic        s1_tx_eof_n,
    input  logic        s1_tx_src_rdy_n,
    output logic        s1_tx_dst_rdy_n,
    output logic [15:0] gtx_tx_data,
    output logic        gtx_tx_sof_n,
    output logic        gtx_tx_eof_n,
    output logic        gtx_tx_src_rdy_n,
    input  logic        gtx_tx_dst_rdy_n,
    output logic        trunc_err,
    output logic        abort_err,
    output logic        sof_err,
    output logic [15:0] frm_cnt0,
    output logic [15:0] frm_cnt1
);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN} state_t;

    // Word index of the last word that fits in a frame.
    localparam logic [15:0] LAST_WORD = 16'(MAX_WORDS - 1);

    // Reset synchronizer. It clears at once when rst_gtp_n falls, and sets
    // two clk_gtp edges after rst_gtp_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
        if (!rst_gtp_n) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t      r_state, w_state_next;
    logic        r_grant, w_grant_next;
    logic        r_prio,  w_prio_next;
    logic [15:0] r_wcnt,  w_wcnt_next;
    logic [15:0] r_frm0,  w_frm0_next;
    logic [15:0] r_frm1,  w_frm1_next;

    always_ff @(posedge clk_gtp or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
            r_wcnt  <= 16'd0;
            r_frm0  <= 16'd0;
            r_frm1  <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_prio  <= w_prio_next;
            r_wcnt  <= w_wcnt_next;
            r_frm0  <= w_frm0_next;
            r_frm1  <= w_frm1_next;
        end
    end

    // Signals of the granted requester.
    logic [15:0] w_g_data;
    logic        w_g_sof_n, w_g_eof_n, w_g_src_n;
    logic        w_s0_req, w_s1_req;

    assign w_g_data  = r_grant ? s1_tx_data      : s0_tx_data;
    assign w_g_sof_n = r_grant ? s1_tx_sof_n     : s0_tx_sof_n;
    assign w_g_eof_n = r_grant ? s1_tx_eof_n     : s0_tx_eof_n;
    assign w_g_src_n = r_grant ? s1_tx_src_rdy_n : s0_tx_src_rdy_n;
    assign w_s0_req  = !s0_tx_src_rdy_n && !s0_tx_sof_n;
    assign w_s1_req  = !s1_tx_src_rdy_n && !s1_tx_sof_n;

    assign frm_cnt0 = r_frm0;
    assign frm_cnt1 = r_frm1;

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_prio_next      = r_prio;
        w_wcnt_next      = r_wcnt;
        w_frm0_next      = r_frm0;
        w_frm1_next      = r_frm1;
        gtx_tx_data      = 16'd0;
        gtx_tx_sof_n     = 1'b1;
        gtx_tx_eof_n     = 1'b1;
        gtx_tx_src_rdy_n = 1'b1;
        s0_tx_dst_rdy_n  = 1'b1;
        s1_tx_dst_rdy_n  = 1'b1;
        trunc_err        = 1'b0;
        abort_err        = 1'b0;
        sof_err          = 1'b0;

        // While reset is held, every output stays at its idle value.
        if (w_rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (channel_up) begin
                        // A word without SOF cannot start a frame. Accept it
                        // and drop it, so the requester does not block.
                        if (!s0_tx_src_rdy_n && s0_tx_sof_n) begin
                            s0_tx_dst_rdy_n = 1'b0;
                            sof_err         = 1'b1;
                        end
                        if (!s1_tx_src_rdy_n && s1_tx_sof_n) begin
                            s1_tx_dst_rdy_n = 1'b0;
                            sof_err         = 1'b1;
                        end
                        if (w_s0_req || w_s1_req) begin
                            w_grant_next = (w_s0_req && w_s1_req) ? r_prio : w_s1_req;
                            w_wcnt_next  = 16'd0;
                            w_state_next = ST_XFER;
                        end
                    end
                end

                ST_XFER: begin
                    gtx_tx_data  = w_g_data;
                    gtx_tx_sof_n = w_g_sof_n;
                    if (!channel_up) begin
                        // An abort wins over anything else this cycle. Neither
                        // side completes a handshake, so the word is held for
                        // the drain.
                        abort_err    = 1'b1;
                        w_state_next = ST_DRAIN;
                    end else begin
                        gtx_tx_eof_n     = w_g_eof_n;
                        gtx_tx_src_rdy_n = w_g_src_n;
                        if (r_grant) s1_tx_dst_rdy_n = gtx_tx_dst_rdy_n;
                        else         s0_tx_dst_rdy_n = gtx_tx_dst_rdy_n;
                        if (!w_g_src_n && !gtx_tx_dst_rdy_n) begin
                            w_wcnt_next = r_wcnt + 16'd1;
                            if (!w_g_eof_n) begin
                                if (r_grant) w_frm1_next = r_frm1 + 16'd1;
                                else         w_frm0_next = r_frm0 + 16'd1;
                                w_prio_next  = ~r_grant;
                                w_state_next = ST_IDLE;
                            end else if (r_wcnt == LAST_WORD) begin
                                gtx_tx_eof_n = 1'b0;
                                trunc_err    = 1'b1;
                                w_state_next = ST_DRAIN;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (r_grant) s1_tx_dst_rdy_n = 1'b0;
                    else         s0_tx_dst_rdy_n = 1'b0;
                    if (!w_g_src_n && !w_g_eof_n) begin
                        w_prio_next  = ~r_grant;
                        w_state_next = ST_IDLE;
                    end
                end

                default: w_state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gtx_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_gtx_tx_arb
// Directed testbench for gtx_tx_arb, built with MAX_WORDS = 8. Inputs change
// 1 ns after a rising edge. Outputs are sampled 2 ns later, well clear of
// either clock edge.
// ---------------------------------------------------------------------------
module tb_gtx_tx_arb;

    logic        clk_gtp = 1'b0;
    logic        rst_gtp_n = 1'b0;
    logic        channel_up = 1'b0;
    logic [15:0] s0_tx_data = 16'd0, s1_tx_data = 16'd0;
    logic        s0_tx_sof_n = 1'b1, s0_tx_eof_n = 1'b1, s0_tx_src_rdy_n = 1'b1;
    logic        s1_tx_sof_n = 1'b1, s1_tx_eof_n = 1'b1, s1_tx_src_rdy_n = 1'b1;
    logic        s0_tx_dst_rdy_n, s1_tx_dst_rdy_n;
    logic [15:0] gtx_tx_data;
    logic        gtx_tx_sof_n, gtx_tx_eof_n, gtx_tx_src_rdy_n;
    logic        gtx_tx_dst_rdy_n = 1'b0;
    logic        trunc_err, abort_err, sof_err;
    logic [15:0] frm_cnt0, frm_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk_gtp = ~clk_gtp;

    gtx_tx_arb #(.MAX_WORDS(8)) dut (
        .clk_gtp(clk_gtp), .rst_gtp_n(rst_gtp_n), .channel_up(channel_up),
        .s0_tx_data(s0_tx_data), .s0_tx_sof_n(s0_tx_sof_n), .s0_tx_eof_n(s0_tx_eof_n),
        .s0_tx_src_rdy_n(s0_tx_src_rdy_n), .s0_tx_dst_rdy_n(s0_tx_dst_rdy_n),
        .s1_tx_data(s1_tx_data), .s1_tx_sof_n(s1_tx_sof_n), .s1_tx_eof_n(s1_tx_eof_n),
        .s1_tx_src_rdy_n(s1_tx_src_rdy_n), .s1_tx_dst_rdy_n(s1_tx_dst_rdy_n),
        .gtx_tx_data(gtx_tx_data), .gtx_tx_sof_n(gtx_tx_sof_n), .gtx_tx_eof_n(gtx_tx_eof_n),
        .gtx_tx_src_rdy_n(gtx_tx_src_rdy_n), .gtx_tx_dst_rdy_n(gtx_tx_dst_rdy_n),
        .trunc_err(trunc_err), .abort_err(abort_err), .sof_err(sof_err),
        .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_gtp);
        #1;
    endtask

    task automatic drive(input int side, input logic [15:0] d, input logic sof_n,
                         input logic eof_n, input logic src_n);
        if (side == 0) begin
            s0_tx_data = d; s0_tx_sof_n = sof_n; s0_tx_eof_n = eof_n; s0_tx_src_rdy_n = src_n;
        end else begin
            s1_tx_data = d; s1_tx_sof_n = sof_n; s1_tx_eof_n = eof_n; s1_tx_src_rdy_n = src_n;
        end
    endtask

    // Drives one frame of n words (base, base+1, ...) on one side. The source
    // moves to its next word only after its own handshake. Every output
    // transfer is checked against the next expected word. The task reports
    // the statistics, and the caller compares them with hand-derived values.
    task automatic send_frame(input int side, input int n, input logic [15:0] base,
                              input bit toggle, input int drop_at,
                              output int n_out, output int eof_at, output int n_trunc,
                              output int n_abort, output int cycles);
        int  in_idx = 0;
        int  cyc = 0;
        bit  acc;
        n_out = 0; eof_at = 0; n_trunc = 0; n_abort = 0;
        while (in_idx < n && cyc < 100) begin
            if (drop_at >= 0 && in_idx == drop_at) channel_up = 1'b0;
            gtx_tx_dst_rdy_n = toggle ? 1'((cyc & 1)) : 1'b0;
            drive(side, base + 16'(in_idx), (in_idx == 0) ? 1'b0 : 1'b1,
                  (in_idx == n - 1) ? 1'b0 : 1'b1, 1'b0);
            #2;
            if (gtx_tx_src_rdy_n === 1'b0 && gtx_tx_dst_rdy_n === 1'b0) begin
                check("tx_data", 32'(gtx_tx_data), 32'(base + 16'(n_out)));
                if (gtx_tx_eof_n === 1'b0) eof_at = n_out + 1;
                n_out++;
            end
            if (gtx_tx_src_rdy_n === 1'b0)
                check("dst_follow", 32'(side ? s1_tx_dst_rdy_n : s0_tx_dst_rdy_n),
                      32'(gtx_tx_dst_rdy_n));
            if (trunc_err === 1'b1) n_trunc++;
            if (abort_err === 1'b1) n_abort++;
            acc = ((side ? s1_tx_dst_rdy_n : s0_tx_dst_rdy_n) === 1'b0);
            step();
            cyc++;
            if (acc) in_idx++;
        end
        drive(side, 16'd0, 1'b1, 1'b1, 1'b1);
        gtx_tx_dst_rdy_n = 1'b0;
        cycles = cyc;
        if (in_idx < n) check("frame_timeout", 32'(in_idx), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_out, eof_at, n_trunc, n_abort, cycles;
        int idx0, idx1, fr0, fr1, outf, outw, cyc;
        bit a0, a1;

        // ---- Reset state: a non-SOF word is presented with the channel up,
        //      and it must not get a dst_rdy while reset is held.
        channel_up = 1'b1;
        drive(0, 16'h1234, 1'b1, 1'b1, 1'b0);
        step(); step(); #2;
        check("rst_gtx_src", 32'(gtx_tx_src_rdy_n), 32'd1);
        check("rst_gtx_sof", 32'(gtx_tx_sof_n), 32'd1);
        check("rst_gtx_eof", 32'(gtx_tx_eof_n), 32'd1);
        check("rst_gtx_data", 32'(gtx_tx_data), 32'd0);
        check("rst_s0_dst", 32'(s0_tx_dst_rdy_n), 32'd1);
        check("rst_s1_dst", 32'(s1_tx_dst_rdy_n), 32'd1);
        check("rst_errs", {29'd0, trunc_err, abort_err, sof_err}, 32'd0);
        check("rst_frm", {frm_cnt0, frm_cnt1}, 32'd0);
        drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
        step();
        rst_gtp_n = 1'b1;
        step(); step(); step();

        // ---- A non-SOF word in IDLE is discarded and sof_err pulses.
        //      No grant is made.
        drive(0, 16'h5555, 1'b1, 1'b1, 1'b0);
        #2;
        check("sof_dst", 32'(s0_tx_dst_rdy_n), 32'd0);
        check("sof_err", 32'(sof_err), 32'd1);
        step(); #2;
        check("sof_nogrant", 32'(gtx_tx_src_rdy_n), 32'd1);
        check("sof_err_idle", 32'(sof_err), 32'd1);
        drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
        #1;
        check("sof_err_clr", 32'(sof_err), 32'd0);
        step();

        // ---- A 4-word frame on s0 passes through unchanged. The cycle count
        //      is 1 IDLE cycle plus 4 transfers.
        send_frame(0, 4, 16'hA000, 1'b0, -1, n_out, eof_at, n_trunc, n_abort, cycles);
        check("f4_nout", 32'(n_out), 32'd4);
        check("f4_eof", 32'(eof_at), 32'd4);
        check("f4_cycles", 32'(cycles), 32'd5);
        check("f4_frm0", 32'(frm_cnt0), 32'd1);
        #2;
        check("f4_idle", 32'(gtx_tx_src_rdy_n), 32'd1);
        step();

        // ---- Reset during a frame: the outputs return to their reset values
        //      at once, and no error pulse is produced.
        drive(0, 16'hC000, 1'b0, 1'b1, 1'b0);
        step(); #2;
        check("mr_in_xfer", 32'(gtx_tx_src_rdy_n), 32'd0);
        rst_gtp_n = 1'b0;
        #1;
        check("mr_gtx_src", 32'(gtx_tx_src_rdy_n), 32'd1);
        check("mr_gtx_sof", 32'(gtx_tx_sof_n), 32'd1);
        check("mr_gtx_data", 32'(gtx_tx_data), 32'd0);
        check("mr_s0_dst", 32'(s0_tx_dst_rdy_n), 32'd1);
        check("mr_frm0", 32'(frm_cnt0), 32'd0);
        check("mr_errs", {29'd0, trunc_err, abort_err, sof_err}, 32'd0);
        drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
        step();
        rst_gtp_n = 1'b1;
        step(); step(); step();

        // ---- Both sides keep offering 3-word frames. After reset the pointer
        //      is 0, so the grants go s0, s1, s0, s1. Words are coded as
        //      base(side) + 16*frame + word. Each frame takes 3 transfers plus
        //      1 IDLE cycle, so 16 cycles in all.
        idx0 = 0; idx1 = 0; fr0 = 0; fr1 = 0; outf = 0; outw = 0; cyc = 0;
        while (outf < 4 && cyc < 60) begin
            if (fr0 < 2) drive(0, 16'hA000 + 16'(fr0 * 16 + idx0), (idx0 == 0) ? 1'b0 : 1'b1,
                               (idx0 == 2) ? 1'b0 : 1'b1, 1'b0);
            else         drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
            if (fr1 < 2) drive(1, 16'hB000 + 16'(fr1 * 16 + idx1), (idx1 == 0) ? 1'b0 : 1'b1,
                               (idx1 == 2) ? 1'b0 : 1'b1, 1'b0);
            else         drive(1, 16'd0, 1'b1, 1'b1, 1'b1);
            #2;
            if (gtx_tx_src_rdy_n === 1'b0 && gtx_tx_dst_rdy_n === 1'b0) begin
                check("alt_data", 32'(gtx_tx_data),
                      32'((((outf % 2) == 1) ? 16'hB000 : 16'hA000) + 16'((outf / 2) * 16 + outw)));
                check("alt_eof", 32'(gtx_tx_eof_n), (outw == 2) ? 32'd0 : 32'd1);
                outw++;
                if (outw == 3) begin outw = 0; outf++; end
            end
            a0 = (s0_tx_src_rdy_n === 1'b0 && s0_tx_dst_rdy_n === 1'b0);
            a1 = (s1_tx_src_rdy_n === 1'b0 && s1_tx_dst_rdy_n === 1'b0);
            step();
            cyc++;
            if (a0) begin idx0++; if (idx0 == 3) begin idx0 = 0; fr0++; end end
            if (a1) begin idx1++; if (idx1 == 3) begin idx1 = 0; fr1++; end end
        end
        drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
        drive(1, 16'd0, 1'b1, 1'b1, 1'b1);
        check("alt_cycles", 32'(cyc), 32'd16);
        check("alt_frm0", 32'(frm_cnt0), 32'd2);
        check("alt_frm1", 32'(frm_cnt1), 32'd2);

        // ---- A 12-word frame on s1 with MAX_WORDS=8: 8 words go out, with
        //      EOF on word 8, and 4 are drained. No count is added.
        send_frame(1, 12, 16'hB100, 1'b0, -1, n_out, eof_at, n_trunc, n_abort, cycles);
        check("tr_nout", 32'(n_out), 32'd8);
        check("tr_eof", 32'(eof_at), 32'd8);
        check("tr_pulses", 32'(n_trunc), 32'd1);
        check("tr_cycles", 32'(cycles), 32'd13);
        check("tr_frm1", 32'(frm_cnt1), 32'd2);

        // ---- The channel drops at word 3 of a 6-word frame on s0. Words 1-2
        //      go out, then there is 1 abort cycle, then words 3-6 are drained.
        send_frame(0, 6, 16'hA200, 1'b0, 2, n_out, eof_at, n_trunc, n_abort, cycles);
        check("ab_nout", 32'(n_out), 32'd2);
        check("ab_eof", 32'(eof_at), 32'd0);
        check("ab_pulses", 32'(n_abort), 32'd1);
        check("ab_cycles", 32'(cycles), 32'd8);
        check("ab_frm0", 32'(frm_cnt0), 32'd2);
        drive(0, 16'hA300, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("ab_nogrant_src", 32'(gtx_tx_src_rdy_n), 32'd1);
            check("ab_nogrant_dst", 32'(s0_tx_dst_rdy_n), 32'd1);
            step();
        end
        drive(0, 16'd0, 1'b1, 1'b1, 1'b1);
        channel_up = 1'b1;
        step();

        // ---- gtx_tx_dst_rdy_n toggles every cycle. Every word arrives
        //      exactly once and in order, and s1 stalls in lockstep
        //      (dst_follow is checked inside the task).
        send_frame(1, 5, 16'hB400, 1'b1, -1, n_out, eof_at, n_trunc, n_abort, cycles);
        check("tg_nout", 32'(n_out), 32'd5);
        check("tg_eof", 32'(eof_at), 32'd5);
        check("tg_frm1", 32'(frm_cnt1), 32'd3);

        // ---- A single-word frame, with SOF and EOF on the same word.
        send_frame(0, 1, 16'hA500, 1'b0, -1, n_out, eof_at, n_trunc, n_abort, cycles);
        check("sw_nout", 32'(n_out), 32'd1);
        check("sw_eof", 32'(eof_at), 32'd1);
        check("sw_cycles", 32'(cycles), 32'd2);
        check("sw_frm0", 32'(frm_cnt0), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
